// File: rtl/dm_arbiter_if.sv
// Signal bundle between the two DM requesters, dm_arbiter and the data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dm_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  p0_req;
  logic                  p0_we;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic                  p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic                  dm_R;
  logic                  dm_W;
  logic [ADDR_WIDTH-1:0] dm_Addr;
  logic [DATA_WIDTH-1:0] dm_W_data;
  logic [DATA_WIDTH-1:0] dm_R_data;
  logic                  busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  dm_R_data,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output dm_R, dm_W, dm_Addr, dm_W_data, busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output dm_R_data,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  dm_R, dm_W, dm_Addr, dm_W_data, busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port data memory.
// Define DM_ARB_FIXED_PRIO_EN to give p0 absolute priority instead of round-robin.
module dm_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  load;
  logic                  sel;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  dm_r_q;
  logic                  dm_w_q;
  logic [ADDR_WIDTH-1:0] dm_addr_q;
  logic [DATA_WIDTH-1:0] dm_wdata_q;
  logic                  gnt0_q;
  logic                  gnt1_q;
  logic                  rvalid0_q;
  logic                  rvalid1_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic                  busy_q;
`ifndef DM_ARB_FIXED_PRIO_EN
  logic                  last_gnt;
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    sel       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          load      = 1'b1;
          state_nxt = ISSUE;
          if (bus.p0_req && bus.p1_req) begin
`ifdef DM_ARB_FIXED_PRIO_EN
            sel = 1'b0;
`else
            sel = ~last_gnt;
`endif
          end else begin
            sel = bus.p1_req;
          end
        end
      end
      // dm_W is high exactly during a write ISSUE, so it doubles as the latched we
      ISSUE:   state_nxt = dm_w_q ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    sel_we    = sel ? bus.p1_we    : bus.p0_we;
    sel_addr  = sel ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = sel ? bus.p1_wdata : bus.p0_wdata;
  end

  // Every output is registered from the next-state decision of the current cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dm_r_q     <= 1'b0;
      dm_w_q     <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_q     <= 1'b0;
`ifndef DM_ARB_FIXED_PRIO_EN
      last_gnt   <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      dm_r_q    <= load & ~sel_we;
      dm_w_q    <= load &  sel_we;
      gnt0_q    <= load & ~sel;
      gnt1_q    <= load &  sel;
      rvalid0_q <= dm_r_q & gnt0_q;
      rvalid1_q <= dm_r_q & gnt1_q;
      busy_q    <= (state_nxt != IDLE);
      if (load) begin
        dm_addr_q  <= sel_addr;
        dm_wdata_q <= sel_wdata;
`ifndef DM_ARB_FIXED_PRIO_EN
        last_gnt   <= sel;
`endif
      end
      if (rvalid0_q) rdata0_q <= bus.dm_R_data;
      if (rvalid1_q) rdata1_q <= bus.dm_R_data;
    end
  end

  // DM's own output register supplies the read word during RESP; the hold
  // registers keep it afterwards so rdata stays put until the next read.
  assign bus.p0_rdata  = rvalid0_q ? bus.dm_R_data : rdata0_q;
  assign bus.p1_rdata  = rvalid1_q ? bus.dm_R_data : rdata1_q;
  assign bus.p0_gnt    = gnt0_q;
  assign bus.p1_gnt    = gnt1_q;
  assign bus.p0_rvalid = rvalid0_q;
  assign bus.p1_rvalid = rvalid1_q;
  assign bus.dm_R      = dm_r_q;
  assign bus.dm_W      = dm_w_q;
  assign bus.dm_Addr   = dm_addr_q;
  assign bus.dm_W_data = dm_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized scoreboard bench for dm_arbiter with a behavioural DM and reference model.
module tb_dm_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int MEMW = 1024;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  dm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural DM: one-cycle registered read, write on strobe
  logic [DW-1:0] mem [MEMW];
  logic [DW-1:0] dm_rd;
  bit            preloaded;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < MEMW; i++) mem[i] <= DW'(i);
      dm_rd     <= '0;
      preloaded <= 1'b1;
    end else begin
      if (bus.dm_W) mem[bus.dm_Addr[9:0]] <= bus.dm_W_data;
      if (bus.dm_R) dm_rd <= mem[bus.dm_Addr[9:0]];
    end
  end
  assign bus.dm_R_data = dm_rd;

  // Reference memory contents, updated in grant order
  logic [DW-1:0] ref_mem [MEMW];
  initial for (int i = 0; i < MEMW; i++) ref_mem[i] = DW'(i);

  acc_t exp_acc0[$];
  acc_t exp_acc1[$];

  task automatic set_port(input int p, input logic req, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? bus.p0_gnt : bus.p1_gnt;
  endfunction

  // Present one request and hold it through its grant cycle; returns one cycle later
  task automatic access(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    acc_t t;
    int   n;
    t = '{we: we, addr: a, wdata: d};
    if (p == 0) exp_acc0.push_back(t); else exp_acc1.push_back(t);
    set_port(p, 1'b1, we, a, d);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!gnt_of(p) && n < 40);
    checks++;
    if (!gnt_of(p)) begin
      errors++;
      $display("FAIL gnt_timeout p%0d: no grant after %0d cycles, expected a grant", p, n);
      if (p == 0) void'(exp_acc0.pop_back()); else void'(exp_acc1.pop_back());
      set_port(p, 1'b0, 1'b0, '0, '0);
    end
    @(posedge clk); #1;
  endtask

  // Monitor / reference model: derives each cycle's expected grant, strobes,
  // read response and busy from the requests seen at the previous edge.
  int            exp_g;
  int            exp_r;
  int            resp_next = -1;
  int            last_win  = 1;
  bit            prev_idle = 1'b1;
  logic          prq0, prq1;
  logic [DW-1:0] rd_exp, held0, held1;
  acc_t          a;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_acc0.delete();
      exp_acc1.delete();
      resp_next = -1;
      last_win  = 1;
      prev_idle = 1'b1;
      held0     = '0;
      held1     = '0;
      prq0      = bus.p0_req;
      prq1      = bus.p1_req;
    end else begin
      exp_g = -1;
      if (prev_idle && (prq0 || prq1)) begin
        if (prq0 && prq1) begin
`ifdef DM_ARB_FIXED_PRIO_EN
          exp_g = 0;
`else
          exp_g = 1 - last_win;
`endif
        end else begin
          exp_g = prq1 ? 1 : 0;
        end
      end
      exp_r     = resp_next;
      resp_next = -1;
      check("p0_gnt", 64'(bus.p0_gnt), 64'(exp_g == 0));
      check("p1_gnt", 64'(bus.p1_gnt), 64'(exp_g == 1));
      if (exp_g >= 0) begin
        last_win = exp_g;
        checks++;
        if ((exp_g == 0 && exp_acc0.size() == 0) || (exp_g == 1 && exp_acc1.size() == 0)) begin
          errors++;
          $display("FAIL grant_without_request p%0d: got a grant, expected none queued", exp_g);
        end else begin
          if (exp_g == 0) a = exp_acc0.pop_front(); else a = exp_acc1.pop_front();
          check("dm_W", 64'(bus.dm_W), 64'(a.we));
          check("dm_R", 64'(bus.dm_R), 64'(!a.we));
          check("dm_Addr", 64'(bus.dm_Addr), 64'(a.addr));
          if (a.we) begin
            check("dm_W_data", 64'(bus.dm_W_data), 64'(a.wdata));
            ref_mem[a.addr[9:0]] = a.wdata;
          end else begin
            rd_exp    = ref_mem[a.addr[9:0]];
            resp_next = exp_g;
          end
        end
      end else begin
        check("dm_R_idle", 64'(bus.dm_R), 64'(0));
        check("dm_W_idle", 64'(bus.dm_W), 64'(0));
      end
      check("p0_rvalid", 64'(bus.p0_rvalid), 64'(exp_r == 0));
      check("p1_rvalid", 64'(bus.p1_rvalid), 64'(exp_r == 1));
      if (exp_r == 0) held0 = rd_exp;
      if (exp_r == 1) held1 = rd_exp;
      check("p0_rdata", 64'(bus.p0_rdata), 64'(held0));
      check("p1_rdata", 64'(bus.p1_rdata), 64'(held1));
      check("busy", 64'(bus.busy), 64'(exp_g >= 0 || exp_r >= 0));
      prev_idle = !(exp_g >= 0 || exp_r >= 0);
      prq0      = bus.p0_req;
      prq1      = bus.p1_req;
    end
  end

  task automatic rand_traffic(input int p);
    int gap;
    for (int n = 0; n < 30; n++) begin
      access(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        set_port(p, 1'b0, 1'b0, '0, '0);
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    set_port(p, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_p0_gnt", 64'(bus.p0_gnt), 64'(0));
    check("rst_p0_rvalid", 64'(bus.p0_rvalid), 64'(0));
    check("rst_p0_rdata", 64'(bus.p0_rdata), 64'(0));
    check("rst_p1_gnt", 64'(bus.p1_gnt), 64'(0));
    check("rst_p1_rvalid", 64'(bus.p1_rvalid), 64'(0));
    check("rst_p1_rdata", 64'(bus.p1_rdata), 64'(0));
    check("rst_dm_R", 64'(bus.dm_R), 64'(0));
    check("rst_dm_W", 64'(bus.dm_W), 64'(0));
    check("rst_dm_Addr", 64'(bus.dm_Addr), 64'(0));
    check("rst_dm_W_data", 64'(bus.dm_W_data), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Write then read back through the other port
    access(0, 1'b1, 16'h0010, 32'hDEADBEEF);
    set_port(0, 1'b0, 1'b0, '0, '0);
    access(1, 1'b0, 16'h0010, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;

    // Both ports hold read requests continuously
    fork
      begin
        for (int i = 0; i < 4; i++) access(0, 1'b0, 16'h0003, '0);
        set_port(0, 1'b0, 1'b0, '0, '0);
      end
      begin
        for (int i = 0; i < 4; i++) access(1, 1'b0, 16'h0005, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back writes on p1, then readback
    for (int i = 1; i <= 4; i++) access(1, 1'b1, AW'(i), DW'($urandom));
    for (int i = 1; i <= 4; i++) access(1, 1'b0, AW'(i), '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;

    fork
      rand_traffic(0);
      rand_traffic(1);
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset asserted during a write's ISSUE cycle
    set_port(0, 1'b1, 1'b1, 16'h0020, 32'hCAFEF00D);
    @(posedge clk); #1;
    check("mid_rst_gnt_before", 64'(bus.p0_gnt), 64'(1));
    check("mid_rst_dm_W_before", 64'(bus.dm_W), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_dm_W", 64'(bus.dm_W), 64'(0));
    check("mid_rst_gnt", 64'(bus.p0_gnt), 64'(0));
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    set_port(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_gnt", 64'(bus.p0_gnt), 64'(0));
    check("post_rst_busy", 64'(bus.busy), 64'(0));
    check("post_rst_mem", 64'(mem[10'h020]), 64'(ref_mem[10'h020]));
    repeat (4) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port data memory (DM).
- Two requesters share DM: p0 is the CPU load/store unit, p1 is the debug/DMA loader.
- Converts each granted request into DM read/write strobes and returns read data with a valid pulse, matching DM's one-cycle registered read latency.

Parameters:
- ADDR_WIDTH, 16, DM word-address width
- DATA_WIDTH, 32, DM data width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- p0_req  in  1  requester 0 access request; held until p0_gnt seen
- p0_we  in  1  1 = write, 0 = read; valid with p0_req
- p0_addr  in  ADDR_WIDTH  word address
- p0_wdata  in  DATA_WIDTH  write data
- p0_gnt  out  1  one-cycle grant pulse
- p0_rvalid  out  1  one-cycle read-data-valid pulse
- p0_rdata  out  DATA_WIDTH  read data, valid when p0_rvalid
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: as p0, for requester 1
- dm_R  out  1  DM read strobe
- dm_W  out  1  DM write strobe
- dm_Addr  out  ADDR_WIDTH  DM address
- dm_W_data  out  DATA_WIDTH  DM write data
- dm_R_data  in  DATA_WIDTH  DM read data; registered inside DM on the posedge where dm_R=1
- busy  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
- All outputs are registered.
- Reset: state=IDLE; every output is 0; last_gnt=1, so p0 wins the first contention.
- IDLE: sample p0_req/p1_req at the edge.
  - Neither request: stay in IDLE.
  - One request: select that port.
  - Both requests: select the port != last_gnt.
  - On a selection: latch we/addr/wdata of the winner, set last_gnt=winner, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - dm_Addr/dm_W_data = latched values.
  - dm_R = !we, dm_W = we.
  - pX_gnt=1 for the winner only.
  - DM performs the access on the edge that ends ISSUE.
  - Next state: write → IDLE; read → RESP.
- RESP (exactly 1 cycle):
  - dm_R=dm_W=0.
  - Winner's pX_rvalid=1 and pX_rdata=dm_R_data; the other port's rdata is unchanged.
  - Next state: IDLE.
- Latency from req sampled in IDLE:
  - gnt 1 cycle later.
  - Read rvalid 2 cycles later.
  - Throughput: write = 1 access per 2 cycles; read = 1 access per 3 cycles.
  - IDLE is always revisited between accesses. That bubble guarantees a requester holding req through its gnt cycle is never double-granted.
- Requester protocol:
  - Hold req/we/addr/wdata stable until the cycle gnt=1.
  - Deassert req, or present a new request, after that cycle.
  - Inputs that change while not granted are ignored until the next IDLE sample.
- pX_rdata holds its last value until the next read for that port.
- gnt and rvalid are never high on both ports in the same cycle.
- Both dm strobes are never high together.
- Reset mid-operation: all strobes drop immediately (asynchronous). A write in ISSUE when rst_n falls before the edge is not performed; the memory contents are otherwise untouched.
- Address and data pass through unmodified; no width conversion.

Optional Feature:
- Macro: DM_ARB_FIXED_PRIO_EN.
- Defined: p0 always wins contention; last_gnt is unused; p1 can starve.
- Undefined (default): round-robin as above.

Test Plan:
- Reset with all inputs 0 → every output 0, busy=0; after release, idle requesters keep busy=0 and dm strobes 0 indefinitely.
- p0 write addr=0x0010, wdata=0xDEADBEEF → p0_gnt with dm_W=1, dm_Addr=0x0010 one cycle after sample. Then p1 read 0x0010 → p1_rvalid 2 cycles after sample with p1_rdata=0xDEADBEEF.
- p0 and p1 both hold read requests (addr 0x0003 and 0x0005) continuously, DM preloaded mem[i]=i → grants alternate p0,p1,p0,p1, one every 3 cycles. rdata: 0x3 on p0, 0x5 on p1.
- Same contention with DM_ARB_FIXED_PRIO_EN defined → p0 granted every time; p1_gnt never asserts while p0_req stays high.
- Back-to-back p1 writes to 0x0001..0x0004 → gnt every 2 cycles; a subsequent readback returns the written data; dm_R never high during those writes.
- rst_n low during a p0 write's ISSUE cycle, before the edge → dm_W drops immediately, the target word keeps its old value, and the FSM is in IDLE with gnt=0 after release.
